// File: rtl/pipeline_control.sv
// RV32I(+M) control-path decoder and D->E->M->W control pipeline.
// A divide in E holds for DIV_CYCLES cycles while upstream stages are stalled.
module pipeline_control #(
    parameter int M_EXT      = 0,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrD,
    input  logic        validD,
    input  logic        flushE,
    output logic [2:0]  ImmSrcD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        JumpRegE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        RD1SrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  TypeE,
    output logic [4:0]  ALUControlE,
    output logic        IllegalE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        StallReq
);
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       jumpreg;
        logic       branch;
        logic       alusrc;
        logic       rd1src;
        logic [1:0] resultsrc;
        logic [2:0] ftype;
        logic [4:0] aluctrl;
        logic       illegal;
    } ectl_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
    } mctl_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
    } wctl_t;

    ectl_t       dec, e_q;
    mctl_t       m_q;
    wctl_t       w_q;
    logic [2:0]  imm_d;
    logic [CW-1:0] cnt;
    logic        div_e;
    logic        stall;

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        unused_instr;

    assign op = instrD[6:0];
    assign f3 = instrD[14:12];
    assign f7 = instrD[31:25];
    assign unused_instr = ^{instrD[24:15], instrD[11:7]};

    always_comb begin
        dec   = '0;
        imm_d = 3'b000;
        if (validD) begin
            case (op)
                OP_R: begin
                    if (f7 == 7'b0000001) begin
                        if (M_EXT != 0) begin
                            dec.regwrite = 1'b1;
                            dec.aluctrl  = {2'b10, f3};
                        end else begin
                            dec.illegal  = 1'b1;
                        end
                    end else begin
                        dec.regwrite = 1'b1;
                        dec.aluctrl  = {1'b0, (f3 == 3'b000 || f3 == 3'b101) ? instrD[30] : 1'b0, f3};
                    end
                end
                OP_I: begin
                    dec.regwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.aluctrl  = {1'b0, (f3 == 3'b101) ? instrD[30] : 1'b0, f3};
                end
                OP_LD: begin
                    dec.regwrite  = 1'b1;
                    dec.resultsrc = 2'b01;
                    dec.alusrc    = 1'b1;
                    dec.ftype     = f3;
                end
                OP_ST: begin
                    dec.memwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.ftype    = f3;
                    imm_d        = 3'b001;
                end
                OP_BR: begin
                    dec.branch  = 1'b1;
                    dec.aluctrl = 5'b01000;
                    dec.ftype   = f3;
                    imm_d       = 3'b010;
                end
                OP_JAL: begin
                    dec.jump      = 1'b1;
                    dec.regwrite  = 1'b1;
                    dec.resultsrc = 2'b10;
                    imm_d         = 3'b100;
                end
                OP_JALR: begin
                    dec.jump      = 1'b1;
                    dec.jumpreg   = 1'b1;
                    dec.regwrite  = 1'b1;
                    dec.resultsrc = 2'b10;
                    dec.alusrc    = 1'b1;
                end
                OP_LUI: begin
                    dec.regwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.aluctrl  = 5'b01111;
                    imm_d        = 3'b011;
                end
                OP_AUI: begin
                    dec.regwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.rd1src   = 1'b1;
                    imm_d        = 3'b011;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // Any M-extension op with funct3[2] set is a divide/remainder.
    assign div_e = (M_EXT != 0) && e_q.aluctrl[4] && e_q.aluctrl[2];
    assign stall = div_e && (cnt != CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
            cnt <= '0;
        end else begin
            w_q <= wctl_t'{m_q.regwrite, m_q.resultsrc};
            if (flushE) begin
                e_q <= '0;
                m_q <= mctl_t'{e_q.regwrite, e_q.memwrite, e_q.resultsrc};
                cnt <= '0;
            end else if (stall) begin
                m_q <= '0;
                cnt <= cnt + CW'(1);
            end else begin
                e_q <= dec;
                m_q <= mctl_t'{e_q.regwrite, e_q.memwrite, e_q.resultsrc};
                cnt <= '0;
            end
        end
    end

    assign ImmSrcD     = imm_d;
    assign RegWriteE   = e_q.regwrite;
    assign MemWriteE   = e_q.memwrite;
    assign JumpE       = e_q.jump;
    assign JumpRegE    = e_q.jumpreg;
    assign BranchE     = e_q.branch;
    assign ALUSrcE     = e_q.alusrc;
    assign RD1SrcE     = e_q.rd1src;
    assign ResultSrcE  = e_q.resultsrc;
    assign TypeE       = e_q.ftype;
    assign ALUControlE = e_q.aluctrl;
    assign IllegalE    = e_q.illegal;
    assign RegWriteM   = m_q.regwrite;
    assign MemWriteM   = m_q.memwrite;
    assign ResultSrcM  = m_q.resultsrc;
    assign RegWriteW   = w_q.regwrite;
    assign ResultSrcW  = w_q.resultsrc;
    assign StallReq    = stall;

endmodule
